// File: rtl/sram_pkg.sv
// Shared constants, FSM encoding and field-merge helper for the masked node-table SRAM.
package sram_pkg;

  localparam int F0_W       = 10;
  localparam int F1_W       = 8;
  localparam int F2_W       = 8;
  localparam int F3_W       = 8;
  localparam int F0_LSB     = 0;
  localparam int F1_LSB     = F0_LSB + F0_W;
  localparam int F2_LSB     = F1_LSB + F1_W;
  localparam int F3_LSB     = F2_LSB + F2_W;
  localparam int DATA_WIDTH = F0_W + F1_W + F2_W + F3_W;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Masked fields come from new_w, the rest keep old_w.
  function automatic logic [DATA_WIDTH-1:0] field_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [3:0]            mask
  );
    logic [DATA_WIDTH-1:0] bm;
    bm = {{F3_W{mask[3]}}, {F2_W{mask[2]}}, {F1_W{mask[1]}}, {F0_W{mask[0]}}};
    return (old_w & ~bm) | (new_w & bm);
  endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset clearing sequencer: sweeps every address once, then parks in READY until the next reset.
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_init_we,
  output logic [ADDR_WIDTH-1:0] o_init_addr,
  output logic                  o_init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    o_init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        o_init_we = 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_READY;
        else                    cnt_d   = cnt_q + ADDR_WIDTH'(1);
      end
      ST_READY: ;
    endcase
  end

  assign o_init_addr = cnt_q;
  assign o_init_done = (state_q == ST_READY);

endmodule

// File: rtl/sram_dp_masked.sv
// Node-table SRAM: one field-masked write port, one registered read port, write-first on address collision.
module sram_dp_masked #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int F0_W       = sram_pkg::F0_W,
  parameter int F1_W       = sram_pkg::F1_W,
  parameter int F2_W       = sram_pkg::F2_W,
  parameter int F3_W       = sram_pkg::F3_W,
  parameter logic [F0_W+F1_W+F2_W+F3_W-1:0] INIT_VALUE = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  output logic                           o_init_done,
  input  logic                           i_write,
  input  logic [ADDR_WIDTH-1:0]          i_wr_addr,
  input  logic [F0_W+F1_W+F2_W+F3_W-1:0] i_wr_data,
  input  logic [3:0]                     i_wr_mask,
  input  logic                           i_read,
  input  logic [ADDR_WIDTH-1:0]          i_rd_addr,
  output logic [F0_W+F1_W+F2_W+F3_W-1:0] o_data,
  output logic                           o_rd_valid,
  output logic                           o_rd_err
);

  localparam int DATA_WIDTH = F0_W + F1_W + F2_W + F3_W;
  localparam int F1_LSB     = F0_W;
  localparam int F2_LSB     = F1_LSB + F1_W;
  localparam int F3_LSB     = F2_LSB + F2_W;
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  init_we, init_done;
  logic [ADDR_WIDTH-1:0] init_addr;

  sram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_init_seq (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_init_we   (init_we),
    .o_init_addr (init_addr),
    .o_init_done (init_done)
  );

  logic wr_oor, rd_oor, wr_fire, rd_fire, wr_hit;
  assign wr_oor  = ({1'b0, i_wr_addr} >= DEPTH_A);
  assign rd_oor  = ({1'b0, i_rd_addr} >= DEPTH_A);
  assign wr_fire = init_done & i_write & ~wr_oor;
  assign rd_fire = init_done & i_read;
  assign wr_hit  = wr_fire & (i_wr_addr == i_rd_addr);

  // Init sweep owns the write port until READY; user writes are never seen during INIT.
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_mask;
  assign mem_we    = init_we | wr_fire;
  assign mem_idx   = init_we ? init_addr[IDX_W-1:0] : i_wr_addr[IDX_W-1:0];
  assign mem_wdata = init_we ? INIT_VALUE : i_wr_data;
  assign mem_mask  = init_we ? 4'hF : i_wr_mask;

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      if (mem_mask[0]) mem[mem_idx][F0_W-1:0]        <= mem_wdata[F0_W-1:0];
      if (mem_mask[1]) mem[mem_idx][F1_LSB +: F1_W]  <= mem_wdata[F1_LSB +: F1_W];
      if (mem_mask[2]) mem[mem_idx][F2_LSB +: F2_W]  <= mem_wdata[F2_LSB +: F2_W];
      if (mem_mask[3]) mem[mem_idx][F3_LSB +: F3_W]  <= mem_wdata[F3_LSB +: F3_W];
    end
  end

  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  vld_q, vld_d, err_q, err_d;

  assign rd_word = mem[i_rd_addr[IDX_W-1:0]];

  always_comb begin
    data_d = data_q;
    vld_d  = 1'b0;
    err_d  = 1'b0;
    if (rd_fire) begin
      vld_d = 1'b1;
      if (rd_oor) begin
        data_d = '0;
        err_d  = 1'b1;
      end else if (wr_hit) begin
        data_d = sram_pkg::field_merge(rd_word, i_wr_data, i_wr_mask);
      end else begin
        data_d = rd_word;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

  assign o_data      = data_q;
  assign o_rd_valid  = vld_q;
  assign o_rd_err    = err_q;
  assign o_init_done = init_done;

endmodule

// File: tb/tb_sram_dp_masked.sv
// Randomized self-checking bench for sram_dp_masked against an array-based reference model.
module tb_sram_dp_masked;

  localparam int AW    = 6;
  localparam int DEPTH = 32;
  localparam int DW    = 34;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic          wr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_mask;
  logic          rd;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rdata;
  logic          rd_valid, rd_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_data;
  logic          exp_vld, exp_err;

  always #5 clk = ~clk;

  sram_dp_masked #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .o_init_done (init_done),
    .i_write     (wr),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_wr_mask   (wr_mask),
    .i_read      (rd),
    .i_rd_addr   (rd_addr),
    .o_data      (rdata),
    .o_rd_valid  (rd_valid),
    .o_rd_err    (rd_err)
  );

  function automatic logic [DW-1:0] mk(input logic [7:0] f3, input logic [7:0] f2,
                                       input logic [7:0] f1, input logic [9:0] f0);
    return {f3, f2, f1, f0};
  endfunction

  // Field of bit b: F0 = bits 0..9, F1 = 10..17, F2 = 18..25, F3 = 26..33.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [3:0] m);
    logic [DW-1:0] res;
    res = o;
    for (int b = 0; b < DW; b++) begin
      int f;
      f = (b < 10) ? 0 : (b < 18) ? 1 : (b < 26) ? 2 : 3;
      if (m[f]) res[b] = n[b];
    end
    return res;
  endfunction

  task automatic idle();
    wr = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd = 1'b0; rd_addr = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_data = '0; exp_vld = 1'b0; exp_err = 1'b0;
  endtask

  // One READY-state cycle: drive, update the reference, clock, release inputs.
  task automatic cycle(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [3:0] m, input logic r, input logic [AW-1:0] ra);
    wr = w; wr_addr = wa; wr_data = wd; wr_mask = m; rd = r; rd_addr = ra;
    exp_vld = r;
    exp_err = 1'b0;
    if (r) begin
      if (int'(ra) < DEPTH) begin
        exp_data = ref_mem[ra[4:0]];
        if (w && wa == ra) exp_data = merge(exp_data, wd, m);
      end else begin
        exp_data = '0;
        exp_err  = 1'b1;
      end
    end
    if (w && int'(wa) < DEPTH) ref_mem[wa[4:0]] = merge(ref_mem[wa[4:0]], wd, m);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset();
    int cycles;
    bit saw_vld;
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 4;
    if (init_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", init_done); end
    if (rdata !== '0)       begin n_bad++; $display("FAIL reset_data: got %h want 0", rdata); end
    if (rd_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_vld: got %b want 0", rd_valid); end
    if (rd_err !== 1'b0)    begin n_bad++; $display("FAIL reset_err: got %b want 0", rd_err); end
    rst = 1'b0;
    cycles = 0;
    saw_vld = 1'b0;
    // Commands issued during the sweep must have no effect.
    while (init_done !== 1'b1 && cycles < 100) begin
      wr = 1'b1; wr_addr = AW'($urandom_range(0, DEPTH-1));
      wr_data = DW'({$urandom, $urandom}); wr_mask = 4'hF;
      rd = 1'b1; rd_addr = AW'($urandom_range(0, DEPTH-1));
      @(posedge clk); #1;
      cycles++;
      if (rd_valid === 1'b1) saw_vld = 1'b1;
    end
    idle();
    model_clear();
    n_cmp += 2;
    if (cycles != DEPTH) begin n_bad++; $display("FAIL init_latency: got %0d want %0d", cycles, DEPTH); end
    if (saw_vld)         begin n_bad++; $display("FAIL init_read_ignored: got valid pulse want none"); end
  endtask

  task automatic test_init_zero();
    for (int a = 0; a < DEPTH; a++) begin
      cycle(1'b0, '0, '0, 4'h0, 1'b1, AW'(a));
      n_cmp += 2;
      if (rdata !== exp_data) begin n_bad++; $display("FAIL init_zero[%0d]: got %h want %h", a, rdata, exp_data); end
      if (rd_valid !== 1'b1)  begin n_bad++; $display("FAIL init_zero_vld[%0d]: got %b want 1", a, rd_valid); end
    end
  endtask

  task automatic test_full_write();
    logic [DW-1:0] w0;
    w0 = mk(8'd100, 8'd0, 8'd0, 10'd245);
    cycle(1'b1, 6'd0, w0, 4'hF, 1'b0, '0);
    n_cmp++;
    if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL write_no_vld: got %b want 0", rd_valid); end
    cycle(1'b0, '0, '0, 4'h0, 1'b1, 6'd0);
    n_cmp += 3;
    if (rdata !== w0)      begin n_bad++; $display("FAIL full_write: got %h want %h", rdata, w0); end
    if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL full_write_vld: got %b want 1", rd_valid); end
    if (rd_err !== 1'b0)   begin n_bad++; $display("FAIL full_write_err: got %b want 0", rd_err); end
    cycle(1'b0, '0, '0, 4'h0, 1'b0, '0);
    n_cmp += 2;
    if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL vld_one_cycle: got %b want 0", rd_valid); end
    if (rdata !== w0)      begin n_bad++; $display("FAIL data_hold: got %h want %h", rdata, w0); end
  endtask

  task automatic test_masked_write();
    cycle(1'b1, 6'd3, mk(8'd100, 8'd0, 8'd0, 10'd485), 4'hF, 1'b0, '0);
    cycle(1'b1, 6'd3, mk(8'd7, 8'd7, 8'd7, 10'd9), 4'b0001, 1'b0, '0);
    cycle(1'b1, 6'd3, mk(8'd1, 8'd2, 8'd3, 10'd4), 4'b0000, 1'b0, '0);
    cycle(1'b0, '0, '0, 4'h0, 1'b1, 6'd3);
    n_cmp++;
    if (rdata !== mk(8'd100, 8'd0, 8'd0, 10'd9))
      begin n_bad++; $display("FAIL masked_write: got %h want %h", rdata, mk(8'd100, 8'd0, 8'd0, 10'd9)); end
  endtask

  task automatic test_same_cycle();
    cycle(1'b1, 6'd5, mk(8'd0, 8'd100, 8'd0, 10'd155), 4'hF, 1'b0, '0);
    cycle(1'b1, 6'd5, mk(8'd0, 8'd0, 8'd100, 10'd595), 4'b1100, 1'b1, 6'd5);
    n_cmp++;
    if (rdata !== mk(8'd0, 8'd0, 8'd0, 10'd155))
      begin n_bad++; $display("FAIL write_first: got %h want %h", rdata, mk(8'd0, 8'd0, 8'd0, 10'd155)); end
    cycle(1'b0, '0, '0, 4'h0, 1'b1, 6'd5);
    n_cmp++;
    if (rdata !== mk(8'd0, 8'd0, 8'd0, 10'd155))
      begin n_bad++; $display("FAIL write_first_reread: got %h want %h", rdata, mk(8'd0, 8'd0, 8'd0, 10'd155)); end
    // Independent ports at different addresses in the same cycle.
    cycle(1'b1, 6'd6, mk(8'd11, 8'd22, 8'd33, 10'd44), 4'hF, 1'b1, 6'd0);
    n_cmp++;
    if (rdata !== exp_data) begin n_bad++; $display("FAIL diff_addr: got %h want %h", rdata, exp_data); end
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] w8;
    w8 = mk(8'd55, 8'd66, 8'd77, 10'd888);
    cycle(1'b1, 6'd8, w8, 4'hF, 1'b0, '0);
    cycle(1'b0, '0, '0, 4'h0, 1'b1, 6'd8);
    cycle(1'b0, '0, '0, 4'h0, 1'b1, 6'd40);
    n_cmp += 3;
    if (rdata !== '0)      begin n_bad++; $display("FAIL oor_data: got %h want 0", rdata); end
    if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL oor_vld: got %b want 1", rd_valid); end
    if (rd_err !== 1'b1)   begin n_bad++; $display("FAIL oor_err: got %b want 1", rd_err); end
    cycle(1'b1, 6'd40, mk(8'd1, 8'd1, 8'd1, 10'd1), 4'hF, 1'b0, '0);
    n_cmp++;
    if (rd_err !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle: got %b want 0", rd_err); end
    cycle(1'b0, '0, '0, 4'h0, 1'b1, 6'd8);
    n_cmp += 2;
    if (rdata !== w8)    begin n_bad++; $display("FAIL no_alias: got %h want %h", rdata, w8); end
    if (rd_err !== 1'b0) begin n_bad++; $display("FAIL in_range_err: got %b want 0", rd_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] wa, ra;
      logic [63:0]   rnd;
      wa  = AW'($urandom_range(0, 39));
      ra  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 39));
      rnd = {$urandom, $urandom};
      cycle(1'($urandom_range(0, 1)), wa, rnd[DW-1:0], 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), ra);
      n_cmp += 3;
      if (rdata !== exp_data)   begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, rdata, exp_data); end
      if (rd_valid !== exp_vld) begin n_bad++; $display("FAIL rand_vld[%0d]: got %b want %b", i, rd_valid, exp_vld); end
      if (rd_err !== exp_err)   begin n_bad++; $display("FAIL rand_err[%0d]: got %b want %b", i, rd_err, exp_err); end
    end
  endtask

  task automatic test_reset_abort();
    int  cycles;
    bit  saw_vld;
    cycle(1'b1, 6'd9, mk(8'd9, 8'd9, 8'd9, 10'd999), 4'hF, 1'b1, 6'd9);
    cycle(1'b0, '0, '0, 4'h0, 1'b1, 6'd9);
    // Pending read, then reset lands before its edge.
    rd = 1'b1; rd_addr = 6'd9;
    #2; rst = 1'b1; #1;
    n_cmp += 3;
    if (rdata !== '0)       begin n_bad++; $display("FAIL abort_data: got %h want 0", rdata); end
    if (init_done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", init_done); end
    if (rd_valid !== 1'b0)  begin n_bad++; $display("FAIL abort_vld: got %b want 0", rd_valid); end
    saw_vld = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (rd_valid === 1'b1) saw_vld = 1'b1;
    end
    idle();
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rd_valid === 1'b1) saw_vld = 1'b1;
    end
    rst = 1'b1; #1;
    n_cmp++;
    if (init_done !== 1'b0) begin n_bad++; $display("FAIL mid_init_abort: got %b want 0", init_done); end
    @(posedge clk); #1;
    rst = 1'b0;
    cycles = 0;
    while (init_done !== 1'b1 && cycles < 100) begin
      rd = 1'b1; rd_addr = AW'($urandom_range(0, DEPTH-1));
      @(posedge clk); #1;
      cycles++;
      if (rd_valid === 1'b1) saw_vld = 1'b1;
    end
    idle();
    model_clear();
    n_cmp += 2;
    if (cycles != DEPTH) begin n_bad++; $display("FAIL restart_latency: got %0d want %0d", cycles, DEPTH); end
    if (saw_vld)         begin n_bad++; $display("FAIL abort_vld_pulse: got pulse want none"); end
    cycle(1'b0, '0, '0, 4'h0, 1'b1, 6'd9);
    n_cmp += 2;
    if (rdata !== exp_data) begin n_bad++; $display("FAIL recleared: got %h want %h", rdata, exp_data); end
    if (rd_valid !== 1'b1)  begin n_bad++; $display("FAIL recleared_vld: got %b want 1", rd_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    model_clear();
    test_reset();
    test_init_zero();
    test_full_write();
    test_masked_write();
    test_same_cycle();
    test_out_of_range();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
